edge_detection_stream_router: RTL and testbench

- Avalon-ST video demultiplexer directly downstream of the edge-detection router-control PIO; consumes its 1-bit out_port as stream_select.
- Steers each complete incoming video packet to either the bypass path (source0) or the edge-detection path (source1).
- Route changes take effect only at packet boundaries, so no frame is ever split across paths.
- Each output has a one-deep registered stage; the two outputs drain independently.

---
 rtl/edge_detection_router_pkg.sv | 19 +
 rtl/edge_detection_stream_router_st_output_register.sv | 44 ++++
 rtl/edge_detection_stream_router.sv | 166 ++++++++++++++++
 tb/tb_edge_detection_stream_router.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_detection_router_pkg.sv
// Shared definitions for the edge-detection stream router: route encodings,
// FSM state type and default stream widths.
package edge_detection_router_pkg;

    // Route encodings, matching the control PIO bit
    localparam logic ROUTE_BYPASS = 1'b0;
    localparam logic ROUTE_EDGE   = 1'b1;

    // Default Avalon-ST widths: one RGB888 pixel per beat, 1-bit empty
    localparam int DEFAULT_DW = 24;
    localparam int DEFAULT_EW = 1;

    // Packet-tracking state of the router
    typedef enum logic {
        IDLE      = 1'b0,
        IN_PACKET = 1'b1
    } router_state_e;

endpackage

// File: rtl/edge_detection_stream_router_st_output_register.sv
// One-deep Avalon-ST pipeline stage. A load captures the beat and raises
// valid. Without a load, a downstream ready drains the stage. A load in a
// cycle where the held beat is also taken keeps 1 beat/cycle throughput.
module st_output_register #(
    parameter int DW = 24,
    parameter int EW = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] in_data,
    input  logic          in_startofpacket,
    input  logic          in_endofpacket,
    input  logic [EW-1:0] in_empty,
    output logic [DW-1:0] out_data,
    output logic          out_startofpacket,
    output logic          out_endofpacket,
    output logic [EW-1:0] out_empty,
    output logic          out_valid,
    input  logic          out_ready
);

    // Valid flag: set on load, cleared once downstream takes the beat
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Payload capture; contents are meaningless while out_valid is low
    always_ff @(posedge clk) begin
        if (load) begin
            out_data          <= in_data;
            out_startofpacket <= in_startofpacket;
            out_endofpacket   <= in_endofpacket;
            out_empty         <= in_empty;
        end
    end

endmodule

// File: rtl/edge_detection_stream_router.sv
// Avalon-ST video demultiplexer. Whole packets are steered to the bypass
// path (source0) or the edge-detection path (source1). The route is
// sampled from stream_select only when an SOP beat is accepted outside a
// packet, so a frame is never split across the two paths.
//
// Handshake: a beat moves on any interface in a cycle where valid and ready
// are both high at the rising clock edge. Ready latency is 0, valid never
// depends combinationally on ready, and data/SOP/EOP/empty are meaningful
// only while valid is high.
module edge_detection_stream_router
    import edge_detection_router_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int EW = DEFAULT_EW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stream_select,
    input  logic [DW-1:0] sink_data,
    input  logic          sink_startofpacket,
    input  logic          sink_endofpacket,
    input  logic [EW-1:0] sink_empty,
    input  logic          sink_valid,
    output logic          sink_ready,
    output logic [DW-1:0] source0_data,
    output logic          source0_startofpacket,
    output logic          source0_endofpacket,
    output logic [EW-1:0] source0_empty,
    output logic          source0_valid,
    input  logic          source0_ready,
    output logic [DW-1:0] source1_data,
    output logic          source1_startofpacket,
    output logic          source1_endofpacket,
    output logic [EW-1:0] source1_empty,
    output logic          source1_valid,
    input  logic          source1_ready,
    output logic          active_route,
    output logic          in_packet,
    output logic          drop_pulse
);

    router_state_e state_q;
    router_state_e state_d;
    logic          active_route_q;
    logic          active_route_d;
    logic          drop_q;
    logic          drop_d;
    logic          dest;
    logic          dest_valid;
    logic          dest_ready;
    logic          accept;
    logic          forward;
    logic          load0;
    logic          load1;

    // Destination selection, sink handshake, next state and register loads
    always_comb begin
        state_d        = state_q;
        active_route_d = active_route_q;
        drop_d         = 1'b0;
        forward        = 1'b0;

        // Outside a packet the live request decides; inside, the latched route
        dest       = (state_q == IDLE) ? stream_select : active_route_q;
        dest_valid = (dest == ROUTE_EDGE) ? source1_valid : source0_valid;
        dest_ready = (dest == ROUTE_EDGE) ? source1_ready : source0_ready;

        // Stray out-of-packet beats are always swallowed so they cannot
        // stall the sink behind a busy output.
        if ((state_q == IDLE) && sink_valid && !sink_startofpacket) begin
            sink_ready = 1'b1;
        end else begin
            sink_ready = !dest_valid || dest_ready;
        end
        accept = sink_valid && sink_ready;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (sink_startofpacket) begin
                        forward        = 1'b1;
                        active_route_d = stream_select;
                        if (!sink_endofpacket) begin
                            state_d = IN_PACKET;
                        end
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end
            IN_PACKET: begin
                // A repeated SOP here is just another beat of this packet
                if (accept) begin
                    forward = 1'b1;
                    if (sink_endofpacket) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        load0 = forward && (dest == ROUTE_BYPASS);
        load1 = forward && (dest == ROUTE_EDGE);
    end

    // FSM state, latched route and drop pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            active_route_q <= ROUTE_BYPASS;
            drop_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            active_route_q <= active_route_d;
            drop_q         <= drop_d;
        end
    end

    assign active_route = active_route_q;
    assign in_packet    = (state_q == IN_PACKET);
    assign drop_pulse   = drop_q;

    // Bypass path output stage
    st_output_register #(
        .DW (DW),
        .EW (EW)
    ) u_source0_reg (
        .clk               (clk),
        .reset             (reset),
        .load              (load0),
        .in_data           (sink_data),
        .in_startofpacket  (sink_startofpacket),
        .in_endofpacket    (sink_endofpacket),
        .in_empty          (sink_empty),
        .out_data          (source0_data),
        .out_startofpacket (source0_startofpacket),
        .out_endofpacket   (source0_endofpacket),
        .out_empty         (source0_empty),
        .out_valid         (source0_valid),
        .out_ready         (source0_ready)
    );

    // Edge-detection path output stage
    st_output_register #(
        .DW (DW),
        .EW (EW)
    ) u_source1_reg (
        .clk               (clk),
        .reset             (reset),
        .load              (load1),
        .in_data           (sink_data),
        .in_startofpacket  (sink_startofpacket),
        .in_endofpacket    (sink_endofpacket),
        .in_empty          (sink_empty),
        .out_data          (source1_data),
        .out_startofpacket (source1_startofpacket),
        .out_endofpacket   (source1_endofpacket),
        .out_empty         (source1_empty),
        .out_valid         (source1_valid),
        .out_ready         (source1_ready)
    );

endmodule

// File: tb/tb_edge_detection_stream_router.sv
// Bench for edge_detection_stream_router: directed scenarios followed by
// randomized packet traffic with random downstream readiness.
module tb_edge_detection_stream_router;

    localparam int DW = 24;
    localparam int EW = 1;
    localparam int BW = DW + 2 + EW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stream_select = 1'b0;
    logic [DW-1:0] sink_data = '0;
    logic          sink_startofpacket = 1'b0;
    logic          sink_endofpacket = 1'b0;
    logic [EW-1:0] sink_empty = '0;
    logic          sink_valid = 1'b0;
    logic          sink_ready;
    logic [DW-1:0] source0_data;
    logic          source0_startofpacket;
    logic          source0_endofpacket;
    logic [EW-1:0] source0_empty;
    logic          source0_valid;
    logic          source0_ready = 1'b1;
    logic [DW-1:0] source1_data;
    logic          source1_startofpacket;
    logic          source1_endofpacket;
    logic [EW-1:0] source1_empty;
    logic          source1_valid;
    logic          source1_ready = 1'b1;
    logic          active_route;
    logic          in_packet;
    logic          drop_pulse;

    edge_detection_stream_router #(
        .DW (DW),
        .EW (EW)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .stream_select         (stream_select),
        .sink_data             (sink_data),
        .sink_startofpacket    (sink_startofpacket),
        .sink_endofpacket      (sink_endofpacket),
        .sink_empty            (sink_empty),
        .sink_valid            (sink_valid),
        .sink_ready            (sink_ready),
        .source0_data          (source0_data),
        .source0_startofpacket (source0_startofpacket),
        .source0_endofpacket   (source0_endofpacket),
        .source0_empty         (source0_empty),
        .source0_valid         (source0_valid),
        .source0_ready         (source0_ready),
        .source1_data          (source1_data),
        .source1_startofpacket (source1_startofpacket),
        .source1_endofpacket   (source1_endofpacket),
        .source1_empty         (source1_empty),
        .source1_valid         (source1_valid),
        .source1_ready         (source1_ready),
        .active_route          (active_route),
        .in_packet             (in_packet),
        .drop_pulse            (drop_pulse)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int failures = 0;
    int drop_seen = 0;
    int exp_drops = 0;
    int inpkt_cycles = 0;

    // Expected beats per output, packed as {data, sop, eop, empty}
    logic [BW-1:0] exp_q0[$];
    logic [BW-1:0] exp_q1[$];

    // Reference model: packet-level routing state
    logic model_in_pkt = 1'b0;
    logic model_route = 1'b0;

    // Ready modes: 0 = random, 1 = held high, 2 = held low
    int ready_mode0 = 1;
    int ready_mode1 = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Rules applied to a beat that the sink accepts
    task automatic model_accept(input logic [DW-1:0] d, input logic sop, input logic eop,
                                input logic [EW-1:0] emp);
        logic [BW-1:0] beat;
        beat = {d, sop, eop, emp};
        if (!model_in_pkt) begin
            if (sop) begin
                model_route = stream_select;
                if (stream_select) exp_q1.push_back(beat);
                else               exp_q0.push_back(beat);
                model_in_pkt = !eop;
            end else begin
                exp_drops++;
            end
        end else begin
            if (model_route) exp_q1.push_back(beat);
            else             exp_q0.push_back(beat);
            if (eop) model_in_pkt = 1'b0;
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            source0_ready = (ready_mode0 == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode0 == 1);
            source1_ready = (ready_mode1 == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode1 == 1);
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic pop_check(input int src, input logic [BW-1:0] got);
        logic [BW-1:0] exp;
        checks++;
        if (src == 0) begin
            if (exp_q0.size() == 0) begin
                failures++;
                $display("FAIL source0_unexpected: got 0x%0h expected no beat at %0t", got, $time);
                return;
            end
            exp = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) begin
                failures++;
                $display("FAIL source1_unexpected: got 0x%0h expected no beat at %0t", got, $time);
                return;
            end
            exp = exp_q1.pop_front();
        end
        if (got !== exp) begin
            failures++;
            $display("FAIL source%0d_beat: got 0x%0h expected 0x%0h at %0t", src, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (source0_valid === 1'b1 && source0_ready)
            pop_check(0, {source0_data, source0_startofpacket, source0_endofpacket, source0_empty});
        if (source1_valid === 1'b1 && source1_ready)
            pop_check(1, {source1_data, source1_startofpacket, source1_endofpacket, source1_empty});
        if (drop_pulse === 1'b1) drop_seen++;
        if (in_packet === 1'b1) inpkt_cycles++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic sop, input logic eop,
                             input logic [EW-1:0] emp);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        sink_data = d;
        sink_startofpacket = sop;
        sink_endofpacket = eop;
        sink_empty = emp;
        sink_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (sink_ready) begin
                model_accept(d, sop, eop, emp);
                done = 1;
            end else if (++n > 200) begin
                checks++;
                failures++;
                $display("FAIL sink_accept_timeout: got no accept expected accept of 0x%0h", d);
                done = 1;
            end
            step();
        end
        sink_valid = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_active_route"}, {31'd0, active_route}, {31'd0, model_route});
        check({tag, "_in_packet"}, {31'd0, in_packet}, {31'd0, model_in_pkt});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        ready_mode0 = 1;
        ready_mode1 = 1;
        step();
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 100) begin
            step();
            n++;
        end
        step();
        check("drain_q0_left", exp_q0.size(), 0);
        check("drain_q1_left", exp_q1.size(), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        exp_q0.delete();
        exp_q1.delete();
        model_in_pkt = 1'b0;
        model_route = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rst_s0_valid", {31'd0, source0_valid}, 0);
        check("rst_s1_valid", {31'd0, source1_valid}, 0);
        check("rst_active_route", {31'd0, active_route}, 0);
        check("rst_in_packet", {31'd0, in_packet}, 0);
        check("rst_drop_pulse", {31'd0, drop_pulse}, 0);
        check("rst_sink_ready", {31'd0, sink_ready}, 1);
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        int len;
        logic sop;

        // 1. reset state
        do_reset();

        // 2. bypass packet, back-to-back
        stream_select = 1'b0;
        inpkt_cycles = 0;
        for (int i = 1; i <= 4; i++)
            send_beat(i[DW-1:0], i == 1, i == 4, 1'b0);
        check_state("bypass");
        repeat (3) step();
        check("bypass_in_packet_cycles", inpkt_cycles, 3);
        wait_drain();

        // 3. select change mid-packet is ignored until next SOP
        stream_select = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) stream_select = 1'b0;
            send_beat(24'h100 + i[DW-1:0], i == 1, i == 8, 1'b0);
        end
        check("midsel_route_latched", {31'd0, active_route}, 1);
        send_beat(24'h200, 1'b1, 1'b0, 1'b0);
        send_beat(24'h201, 1'b0, 1'b1, 1'b1);
        check_state("midsel_next");
        wait_drain();

        // 4. backpressure on the edge path
        stream_select = 1'b1;
        ready_mode1 = 2;
        repeat (2) step();
        send_beat(24'h300, 1'b1, 1'b0, 1'b0);
        sink_data = 24'h301;
        sink_startofpacket = 1'b0;
        sink_endofpacket = 1'b0;
        sink_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_sink_ready_low", {31'd0, sink_ready}, 0);
        end
        ready_mode1 = 1;
        for (int i = 1; i <= 5; i++)
            send_beat(24'h300 + i[DW-1:0], 1'b0, i == 5, 1'b0);
        check_state("bp");
        wait_drain();

        // 5. stray out-of-packet beats
        d0 = drop_seen;
        send_beat(24'hAAAAAA, 1'b0, 1'b0, 1'b0);
        send_beat(24'hBBBBBB, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        check("stray_drop_cycles", drop_seen - d0, 2);
        check_state("stray");
        wait_drain();

        // 6a. single-beat packet
        stream_select = 1'b0;
        send_beat(24'h400, 1'b1, 1'b1, 1'b1);
        check_state("single");
        wait_drain();

        // 6b. reset in the middle of a packet, with a beat held on source0
        stream_select = 1'b0;
        ready_mode0 = 2;
        repeat (2) step();
        send_beat(24'h500, 1'b1, 1'b0, 1'b0);
        do_reset();
        ready_mode0 = 1;
        stream_select = 1'b1;
        send_beat(24'h600, 1'b1, 1'b0, 1'b0);
        send_beat(24'h601, 1'b0, 1'b1, 1'b0);
        check_state("post_reset");
        wait_drain();

        // 7. randomized traffic
        ready_mode0 = 0;
        ready_mode1 = 0;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 4) == 0)
                send_beat(DW'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
            stream_select = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if (b > 0 && $urandom_range(0, 3) == 0) stream_select = ~stream_select;
                sop = (b == 0) || ($urandom_range(0, 15) == 0);
                send_beat(DW'($urandom), sop, b == len - 1,
                          (b == len - 1) ? EW'($urandom_range(0, 1)) : '0);
                if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) step();
            end
            check_state("rand");
        end
        wait_drain();
        repeat (3) step();
        check("total_drops", drop_seen, exp_drops);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
